rs_alu: RTL
===========

Name: rs_alu

Overview:
- Reservation station directly upstream of the single-cycle ALU execution unit.
- Accepts renamed ALU ops from dispatch and holds them until both register operands are valid.
- Snoops the common data bus (CDB) for operand wakeup and issues at most one ready op per cycle to the ALU, together with its ROB tag.

Parameters:
- DEPTH, 4, number of entries (power of 2, 2..16).
- TAG_W, 4, ROB tag width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- i_dp_vld  in  1  dispatch request
- o_dp_rdy  out  1  station can accept a dispatch this cycle
- i_dp_op_sel / i_dp_src1_sel / i_dp_src2_sel  in  `ALU_OP_SEL / `ALU_SRC1_SEL / `ALU_SRC2_SEL  ALU controls
- i_dp_rs1, i_dp_rs2  in  `RV32_DATA_WIDTH each  operand value (meaningful when its valid bit is 1)
- i_dp_rs1_vld, i_dp_rs2_vld  in  1 each  operand already available
- i_dp_rs1_tag, i_dp_rs2_tag  in  TAG_W each  producer ROB tag when operand not valid
- i_dp_pc  in  `RV32_PC_WIDTH  instruction PC
- i_dp_imm  in  `RV32_DATA_WIDTH  immediate
- i_dp_tag  in  TAG_W  ROB tag of this op
- i_cdb_vld  in  1  CDB broadcast valid
- i_cdb_tag  in  TAG_W  broadcast tag
- i_cdb_data  in  `RV32_DATA_WIDTH  broadcast result
- i_kill  in  1  pipeline flush
- i_ex_accessable  in  1  ALU can accept an issue
- o_is_vld  out  1  issue valid
- o_is_op_sel, o_is_src1_sel, o_is_src2_sel, o_is_rs1, o_is_pc, o_is_rs2, o_is_imm  out  same widths as dispatch  issued operands
- o_is_tag  out  TAG_W  ROB tag of the issued op

Behaviour:
- Entry state: busy, fields, rs1_vld/rs1_tag, rs2_vld/rs2_tag.
- Reset (rst=1 at posedge): all busy=0; o_dp_rdy=1, o_is_vld=0 after reset.
- Dispatch:
  - o_dp_rdy = at least one non-busy entry, computed from registered state only (no path from i_dp_vld or from issue).
  - On i_dp_vld & o_dp_rdy, the op is written into the lowest-index free entry at the posedge.
  - i_dp_vld while o_dp_rdy=0 is an upstream protocol error; the station ignores it.
- Dispatch-time capture: if a source is not valid and i_cdb_vld & i_cdb_tag==src tag in the same cycle, the entry is written with that source valid and carrying i_cdb_data.
- Wakeup: every busy entry with an invalid source whose tag matches a valid CDB broadcast latches i_cdb_data and sets valid at the posedge. Both sources may wake in the same cycle.
- Ready: busy & rs1_vld & rs2_vld, from registered state.
- Select: lowest-index ready entry.
- Issue (combinational):
  - o_is_vld = any ready & i_ex_accessable; o_is_* driven from the selected entry.
  - When o_is_vld=0, o_is_* are don't-care but must be stable (selected entry or zero).
  - The issued entry clears busy at the posedge, so the ALU sees result validity one cycle later.
- A freed entry can be redispatched no earlier than the next cycle (o_dp_rdy is registered-based).
- Kill: i_kill=1 clears all busy at the posedge. It overrides same-cycle dispatch and wakeup. o_is_vld in the kill cycle is still driven and the ALU may consume it; the ROB discards it by tag.
- rst has priority over i_kill.

Optional Feature:
- Macro RS_WAKEUP_BYPASS_EN.
- Defined: an entry whose missing operand(s) match the current CDB broadcast counts as ready this cycle, and the issued operand is muxed from i_cdb_data, giving zero-cycle wakeup-to-issue.
- Undefined: wakeup only updates state; issue earliest one cycle after the broadcast.

Decomposition:
- Shared constants header: ALU select widths, data/PC widths, and a new `ROB_TAG_WIDTH constant used as the TAG_W default.
- Sub-module rs_alu_sel: parameterised lowest-index priority picker (ready vector in, one-hot grant and any-grant out).
  - Instanced twice: once for the free-entry picker, once for the ready-entry picker.

Test Plan:
- Dispatch op with both sources valid, rs1=5, rs2=7, tag=3, i_ex_accessable=1 -> o_is_vld=1 next cycle, o_is_rs1=5, o_is_rs2=7, o_is_tag=3; entry freed the following cycle.
- Dispatch with rs2 waiting on tag 9; two cycles later CDB {tag 9, data 0x1234} -> issue next cycle with o_is_rs2=0x1234 (same cycle under RS_WAKEUP_BYPASS_EN).
- Dispatch waiting on tag 2 in the same cycle as CDB tag 2, data 0xAA -> entry ready immediately, issues next cycle with 0xAA.
- Fill DEPTH=4 entries all waiting -> o_dp_rdy=0; the 5th i_dp_vld is ignored. Wake entry 2 -> it issues, and o_dp_rdy=1 the cycle after it frees.
- Two entries ready, i_ex_accessable=0 for 3 cycles -> o_is_vld=0 throughout. On release, entry 0 issues first, then entry 1.
- 3 busy entries plus i_kill asserted with a concurrent dispatch -> all busy=0 next cycle, o_dp_rdy=1, o_is_vld=0.

Source files
------------

// File: rtl/rs_alu_pkg.sv
// rtl/rs_alu_pkg.sv - shared ALU/RV32 widths and per-entry control bundle for the ALU reservation station
package rs_alu_pkg;

  localparam int ALU_OP_SEL_W    = 4;
  localparam int ALU_SRC1_SEL_W  = 2;
  localparam int ALU_SRC2_SEL_W  = 2;
  localparam int RV32_DATA_WIDTH = 32;
  localparam int RV32_PC_WIDTH   = 32;
  localparam int ROB_TAG_WIDTH   = 4;

  // Fields that ride along with the op untouched from dispatch to issue
  typedef struct packed {
    logic [ALU_OP_SEL_W-1:0]    op_sel;
    logic [ALU_SRC1_SEL_W-1:0]  src1_sel;
    logic [ALU_SRC2_SEL_W-1:0]  src2_sel;
    logic [RV32_PC_WIDTH-1:0]   pc;
    logic [RV32_DATA_WIDTH-1:0] imm;
  } rs_ctl_t;

endpackage

// File: rtl/rs_alu_if.sv
// rtl/rs_alu_if.sv - dispatch, CDB, flush and issue signals of the ALU reservation station
interface rs_alu_if
  import rs_alu_pkg::*;
#(
  parameter int TAG_W = ROB_TAG_WIDTH
) ();

  logic                       i_dp_vld;
  logic                       o_dp_rdy;
  logic [ALU_OP_SEL_W-1:0]    i_dp_op_sel;
  logic [ALU_SRC1_SEL_W-1:0]  i_dp_src1_sel;
  logic [ALU_SRC2_SEL_W-1:0]  i_dp_src2_sel;
  logic [RV32_DATA_WIDTH-1:0] i_dp_rs1;
  logic [RV32_DATA_WIDTH-1:0] i_dp_rs2;
  logic                       i_dp_rs1_vld;
  logic                       i_dp_rs2_vld;
  logic [TAG_W-1:0]           i_dp_rs1_tag;
  logic [TAG_W-1:0]           i_dp_rs2_tag;
  logic [RV32_PC_WIDTH-1:0]   i_dp_pc;
  logic [RV32_DATA_WIDTH-1:0] i_dp_imm;
  logic [TAG_W-1:0]           i_dp_tag;

  logic                       i_cdb_vld;
  logic [TAG_W-1:0]           i_cdb_tag;
  logic [RV32_DATA_WIDTH-1:0] i_cdb_data;

  logic                       i_kill;
  logic                       i_ex_accessable;

  logic                       o_is_vld;
  logic [ALU_OP_SEL_W-1:0]    o_is_op_sel;
  logic [ALU_SRC1_SEL_W-1:0]  o_is_src1_sel;
  logic [ALU_SRC2_SEL_W-1:0]  o_is_src2_sel;
  logic [RV32_DATA_WIDTH-1:0] o_is_rs1;
  logic [RV32_PC_WIDTH-1:0]   o_is_pc;
  logic [RV32_DATA_WIDTH-1:0] o_is_rs2;
  logic [RV32_DATA_WIDTH-1:0] o_is_imm;
  logic [TAG_W-1:0]           o_is_tag;

  modport master (
    output i_dp_vld, i_dp_op_sel, i_dp_src1_sel, i_dp_src2_sel,
           i_dp_rs1, i_dp_rs2, i_dp_rs1_vld, i_dp_rs2_vld,
           i_dp_rs1_tag, i_dp_rs2_tag, i_dp_pc, i_dp_imm, i_dp_tag,
           i_cdb_vld, i_cdb_tag, i_cdb_data, i_kill, i_ex_accessable,
    input  o_dp_rdy, o_is_vld, o_is_op_sel, o_is_src1_sel, o_is_src2_sel,
           o_is_rs1, o_is_pc, o_is_rs2, o_is_imm, o_is_tag
  );

  modport slave (
    input  i_dp_vld, i_dp_op_sel, i_dp_src1_sel, i_dp_src2_sel,
           i_dp_rs1, i_dp_rs2, i_dp_rs1_vld, i_dp_rs2_vld,
           i_dp_rs1_tag, i_dp_rs2_tag, i_dp_pc, i_dp_imm, i_dp_tag,
           i_cdb_vld, i_cdb_tag, i_cdb_data, i_kill, i_ex_accessable,
    output o_dp_rdy, o_is_vld, o_is_op_sel, o_is_src1_sel, o_is_src2_sel,
           o_is_rs1, o_is_pc, o_is_rs2, o_is_imm, o_is_tag
  );

endinterface

// File: rtl/rs_alu_sel.sv
// rtl/rs_alu_sel.sv - lowest-index priority picker: one-hot grant plus any-grant flag
module rs_alu_sel #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt,
  output logic         any
);

  // Two's-complement trick isolates the lowest set bit
  assign gnt = req & (~req + N'(1));
  assign any = |req;

endmodule

// File: rtl/rs_alu.sv
// rtl/rs_alu.sv - reservation station feeding the single-cycle ALU; RS_WAKEUP_BYPASS_EN enables same-cycle CDB-to-issue
module rs_alu
  import rs_alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = ROB_TAG_WIDTH
) (
  input logic        clk,
  input logic        rst,
  rs_alu_if.slave    bus
);

  logic [DEPTH-1:0]           busy;
  logic [DEPTH-1:0]           rs1_vld;
  logic [DEPTH-1:0]           rs2_vld;
  rs_ctl_t                    ctl     [DEPTH];
  logic [TAG_W-1:0]           tag_q   [DEPTH];
  logic [TAG_W-1:0]           rs1_tag [DEPTH];
  logic [TAG_W-1:0]           rs2_tag [DEPTH];
  logic [RV32_DATA_WIDTH-1:0] rs1_q   [DEPTH];
  logic [RV32_DATA_WIDTH-1:0] rs2_q   [DEPTH];

  logic [DEPTH-1:0] rs1_hit, rs2_hit, rs1_ok, rs2_ok, ready;
  logic [DEPTH-1:0] free_gnt, is_gnt, issue_clr;
  logic             free_any, is_any, is_vld, dp_we;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      rs1_hit[i] = bus.i_cdb_vld & ~rs1_vld[i] & (rs1_tag[i] == bus.i_cdb_tag);
      rs2_hit[i] = bus.i_cdb_vld & ~rs2_vld[i] & (rs2_tag[i] == bus.i_cdb_tag);
    end
  end

`ifdef RS_WAKEUP_BYPASS_EN
  assign rs1_ok = rs1_vld | rs1_hit;
  assign rs2_ok = rs2_vld | rs2_hit;
`else
  assign rs1_ok = rs1_vld;
  assign rs2_ok = rs2_vld;
`endif

  assign ready = busy & rs1_ok & rs2_ok;

  rs_alu_sel #(.N(DEPTH)) u_free_sel (
    .req (~busy),
    .gnt (free_gnt),
    .any (free_any)
  );

  rs_alu_sel #(.N(DEPTH)) u_rdy_sel (
    .req (ready),
    .gnt (is_gnt),
    .any (is_any)
  );

  assign dp_we     = bus.i_dp_vld & free_any;
  assign is_vld    = is_any & bus.i_ex_accessable;
  assign issue_clr = is_gnt & {DEPTH{is_vld}};

  // Dispatch-time capture of a result broadcast in the same cycle
  rs_ctl_t                    dp_ctl;
  logic                       dp_rs1_cap, dp_rs2_cap;
  logic [RV32_DATA_WIDTH-1:0] dp_rs1, dp_rs2;

  always_comb begin
    dp_ctl.op_sel   = bus.i_dp_op_sel;
    dp_ctl.src1_sel = bus.i_dp_src1_sel;
    dp_ctl.src2_sel = bus.i_dp_src2_sel;
    dp_ctl.pc       = bus.i_dp_pc;
    dp_ctl.imm      = bus.i_dp_imm;
    dp_rs1_cap = ~bus.i_dp_rs1_vld & bus.i_cdb_vld & (bus.i_dp_rs1_tag == bus.i_cdb_tag);
    dp_rs2_cap = ~bus.i_dp_rs2_vld & bus.i_cdb_vld & (bus.i_dp_rs2_tag == bus.i_cdb_tag);
    dp_rs1     = dp_rs1_cap ? bus.i_cdb_data : bus.i_dp_rs1;
    dp_rs2     = dp_rs2_cap ? bus.i_cdb_data : bus.i_dp_rs2;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else if (bus.i_kill) begin
      busy <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (busy[i] && rs1_hit[i]) begin
          rs1_q[i]   <= bus.i_cdb_data;
          rs1_vld[i] <= 1'b1;
        end
        if (busy[i] && rs2_hit[i]) begin
          rs2_q[i]   <= bus.i_cdb_data;
          rs2_vld[i] <= 1'b1;
        end
        if (issue_clr[i]) begin
          busy[i] <= 1'b0;
        end
        // A free slot is never busy, so this cannot collide with wakeup or issue
        if (dp_we && free_gnt[i]) begin
          busy[i]    <= 1'b1;
          ctl[i]     <= dp_ctl;
          tag_q[i]   <= bus.i_dp_tag;
          rs1_q[i]   <= dp_rs1;
          rs1_vld[i] <= bus.i_dp_rs1_vld | dp_rs1_cap;
          rs1_tag[i] <= bus.i_dp_rs1_tag;
          rs2_q[i]   <= dp_rs2;
          rs2_vld[i] <= bus.i_dp_rs2_vld | dp_rs2_cap;
          rs2_tag[i] <= bus.i_dp_rs2_tag;
        end
      end
    end
  end

  // One-hot AND-OR style mux; outputs are zero when nothing is ready
  rs_ctl_t                    is_ctl;
  logic [TAG_W-1:0]           is_tag;
  logic [RV32_DATA_WIDTH-1:0] is_rs1, is_rs2;

  always_comb begin
    is_ctl = '0;
    is_tag = '0;
    is_rs1 = '0;
    is_rs2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (is_gnt[i]) begin
        is_ctl = ctl[i];
        is_tag = tag_q[i];
        is_rs1 = rs1_q[i];
        is_rs2 = rs2_q[i];
`ifdef RS_WAKEUP_BYPASS_EN
        if (rs1_hit[i]) is_rs1 = bus.i_cdb_data;
        if (rs2_hit[i]) is_rs2 = bus.i_cdb_data;
`endif
      end
    end
  end

  assign bus.o_dp_rdy      = free_any;
  assign bus.o_is_vld      = is_vld;
  assign bus.o_is_op_sel   = is_ctl.op_sel;
  assign bus.o_is_src1_sel = is_ctl.src1_sel;
  assign bus.o_is_src2_sel = is_ctl.src2_sel;
  assign bus.o_is_pc       = is_ctl.pc;
  assign bus.o_is_imm      = is_ctl.imm;
  assign bus.o_is_rs1      = is_rs1;
  assign bus.o_is_rs2      = is_rs2;
  assign bus.o_is_tag      = is_tag;

endmodule
